motion_cmd_gen: RTL and testbench
=================================

Name: motion_cmd_gen

Overview:
- Upstream input-conditioning stage for the shape-motion datapath.
- Takes the raw direction switches SW[3:0] and synchronises and debounces each one.
- Resolves priority between simultaneously held switches and produces single move-step commands, with hold-to-auto-repeat.
- Hands each step to the shape-position/redraw logic over a 1-deep valid/ready interface, so the position updates at most once per accepted command instead of per raw clock.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a switch change (1 ms at 50 MHz).
- REPEAT_DELAY, 12500000: cycles from the first step to the first auto-repeat step (250 ms).
- REPEAT_PERIOD, 2500000: cycles between auto-repeat steps (50 ms).

Ports:
- CLK_50  input  1  system clock, 50 MHz; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- SW  input  4  raw switches: [0]=left, [1]=right, [2]=up, [3]=down; asynchronous to CLK_50.
- cmd_ready  input  1  consumer can accept a step this cycle.
- cmd_valid  output  1  a step command is pending.
- cmd_dir  output  2  direction of the pending step: 0=left, 1=right, 2=up, 3=down.
- dir_held  output  4  debounced switch levels, same bit order as SW.
- overrun  output  1  sticky flag: a step was dropped because the previous one was still pending.

Behaviour:
- Reset (asynchronous, resetn=0):
  - All flops clear; cmd_valid=0, cmd_dir=0, dir_held=0, overrun=0.
  - FSM=IDLE, timers=0.
  - Reset asserted mid-operation discards any pending command.
- Synchronisation: two flops per SW bit, reset value 0.
- Debounce, per bit:
  - A counter increments while the synchronised bit differs from the stable bit, and clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while they still differ, the stable bit toggles and the counter clears.
  - dir_held = stable bits, registered.
  - Latency from an SW edge to dir_held: 2 + DEBOUNCE_CYCLES cycles.
- Priority: active direction = left > right > up > down among the dir_held bits; "none" if all are 0.
- Step issue:
  - An internal one-cycle event carrying a direction.
  - It is registered into cmd_valid/cmd_dir on the next clock edge, so cmd_valid rises 1 cycle after the dir_held change that caused it.
- FSM states:
  - IDLE: active dir != none -> issue step(active), load timer REPEAT_DELAY-1, go DELAY.
  - DELAY: active dir == none -> IDLE. Active dir changed to another non-none dir -> issue step(new), reload REPEAT_DELAY-1, stay DELAY. Timer==0 -> issue step, load REPEAT_PERIOD-1, go REPEAT. Otherwise decrement.
  - REPEAT: none -> IDLE. Dir changed -> issue step(new), load REPEAT_DELAY-1, go DELAY. Timer==0 -> issue step, reload REPEAT_PERIOD-1. Otherwise decrement.
- Handshake:
  - A transfer occurs on a cycle with cmd_valid && cmd_ready.
  - cmd_dir is stable while cmd_valid=1 and the consumer has not accepted.
  - cmd_valid does not depend combinationally on cmd_ready.
- Boundary conditions:
  - Issue with no pending command, or coincident with a transfer: load the new step; cmd_valid stays or becomes 1.
  - Issue while cmd_valid=1 and cmd_ready=0: the new step is dropped, the old one is kept, overrun<=1.
  - Transfer with no issue: cmd_valid<=0.
  - Returning to IDLE does not cancel a pending command.
  - overrun clears only on reset.
- Timer width: clog2(max(REPEAT_DELAY, REPEAT_PERIOD)), unsigned, no wrap (reloaded before it underflows).

Decomposition:
- Shared package motion_pkg:
  - direction encoding constants DIR_LEFT=0, DIR_RIGHT=1, DIR_UP=2, DIR_DOWN=3;
  - FSM state encoding IDLE/DELAY/REPEAT.
  - The position-update stage reuses the direction constants.
- One sub-module, sw_debounce (single bit: synchroniser + debounce counter, parameter DEBOUNCE_CYCLES), instantiated 4x.
- Priority resolution, FSM and handshake register stay in motion_cmd_gen.

Test Plan:
Directed scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, with cmd_ready=1 unless stated.
- Reset: resetn=0 mid-repeat with cmd_valid=1 -> all outputs 0 immediately (asynchronously); after release, with no SW held, cmd_valid stays 0.
- Bounce: SW[0] toggles every 2 cycles for 20 cycles, then 0 -> dir_held stays 0000, no cmd_valid. SW[0] held -> dir_held[0]=1 at 6 cycles after the edge, cmd_valid=1 with cmd_dir=0 the next cycle, for 1 cycle.
- Auto-repeat: hold SW[1] for 40 cycles after debounce -> steps with cmd_dir=1 at t0, t0+10, t0+15, t0+20, ... Release -> no further steps after the debounced release.
- Priority and switch: hold SW[3], then add SW[2] -> first step dir=3, then an immediate dir=2 step after SW[2] debounces, and the repeat delay restarts (next step 10 cycles later).
- Backpressure: cmd_ready=0 while repeating SW[0] -> cmd_valid holds with cmd_dir=0, overrun=1 at the first repeat. Raise cmd_ready -> one transfer, then cmd_valid=0 until the next issue.
- Coincident: issue on the same cycle as a transfer -> cmd_valid stays 1 with the new dir, overrun unchanged.

Source files
------------

// File: rtl/motion_pkg.sv
// Shared definitions for the shape-motion datapath: direction encoding,
// command-generator FSM states and the switch priority resolver.
package motion_pkg;

  // Direction encoding, shared with the position-update stage.
  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  // Switch bit positions in SW / dir_held.
  localparam int SW_LEFT  = 0;
  localparam int SW_RIGHT = 1;
  localparam int SW_UP    = 2;
  localparam int SW_DOWN  = 3;

  // Command-generator FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } motion_state_t;

  // Highest-priority held direction: left > right > up > down.
  // Callers check for "none" (all bits low) separately.
  function automatic logic [1:0] prio_dir(input logic [3:0] held);
    logic [1:0] dir;
    if (held[SW_LEFT])       dir = DIR_LEFT;
    else if (held[SW_RIGHT]) dir = DIR_RIGHT;
    else if (held[SW_UP])    dir = DIR_UP;
    else                     dir = DIR_DOWN;
    return dir;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-bit switch conditioner: two-flop synchroniser followed by a
// stability counter. The output only changes after the synchronised input
// has differed from it for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous switch into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive disagreeing cycles; accept the new level once the
  // count expires, restart whenever input and output agree again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_q2 != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync_q2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/motion_cmd_gen.sv
// Motion command generator: debounces the four direction switches, picks
// the highest-priority held direction and emits single step commands with
// hold-to-auto-repeat, buffered in a 1-deep valid/ready output register.
//
// Output handshake: a step transfers on any cycle with cmd_valid && cmd_ready.
// cmd_valid and cmd_dir are pure flops; cmd_dir never changes while a step
// is pending and not yet accepted. A step issued while the previous one is
// still pending and not being accepted is dropped and sets the sticky
// overrun flag; a step issued on a transfer cycle replaces the departing one.
module motion_cmd_gen
  import motion_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic       CLK_50,
  input  logic       resetn,
  input  logic [3:0] SW,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [1:0] cmd_dir,
  output logic [3:0] dir_held,
  output logic       overrun
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DELAY_LOAD  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] PERIOD_LOAD = TW'(REPEAT_PERIOD - 1);

  motion_state_t state;
  logic [TW-1:0] timer;
  logic [1:0]    cur_dir;

  logic          act_any;
  logic [1:0]    act_dir;
  logic          issue;
  logic          xfer;

  // One conditioner per switch; the stable levels are the debounced outputs.
  for (genvar i = 0; i < 4; i++) begin : g_deb
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (CLK_50),
      .rst_n(resetn),
      .sw   (SW[i]),
      .level(dir_held[i])
    );
  end

  // Active direction from the debounced levels.
  always_comb begin
    act_any = |dir_held;
    act_dir = prio_dir(dir_held);
  end

  // Step-issue event: a fresh press, a direction change, or timer expiry.
  always_comb begin
    issue = 1'b0;
    case (state)
      ST_IDLE:   issue = act_any;
      ST_DELAY,
      ST_REPEAT: issue = act_any && ((act_dir != cur_dir) || (timer == '0));
      default:   issue = 1'b0;
    endcase
  end

  assign xfer = cmd_valid && cmd_ready;

  // Repeat FSM plus the registered command buffer and overrun flag.
  always_ff @(posedge CLK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      timer     <= '0;
      cur_dir   <= DIR_LEFT;
      cmd_valid <= 1'b0;
      cmd_dir   <= DIR_LEFT;
      overrun   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (act_any) begin
            state   <= ST_DELAY;
            timer   <= DELAY_LOAD;
            cur_dir <= act_dir;
          end
        end
        ST_DELAY: begin
          if (!act_any) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (act_dir != cur_dir) begin
            cur_dir <= act_dir;
            timer   <= DELAY_LOAD;
          end else if (timer == '0) begin
            state <= ST_REPEAT;
            timer <= PERIOD_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!act_any) begin
            state <= ST_IDLE;
            timer <= '0;
          end else if (act_dir != cur_dir) begin
            state   <= ST_DELAY;
            cur_dir <= act_dir;
            timer   <= DELAY_LOAD;
          end else if (timer == '0) begin
            timer <= PERIOD_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          timer <= '0;
        end
      endcase

      // Output buffer: load on free slot or departing step, else drop.
      if (issue) begin
        if (!cmd_valid || cmd_ready) begin
          cmd_valid <= 1'b1;
          cmd_dir   <= act_dir;
        end else begin
          overrun <= 1'b1;
        end
      end else if (xfer) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_motion_cmd_gen.sv
// Directed bench for motion_cmd_gen with short debounce/repeat timings.
module tb_motion_cmd_gen;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 5;

  logic       CLK_50;
  logic       resetn;
  logic [3:0] SW;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic [3:0] dir_held;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int         xfer_cyc[$];
  logic [1:0] xfer_dir[$];

  motion_cmd_gen #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .CLK_50   (CLK_50),
    .resetn   (resetn),
    .SW       (SW),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .dir_held (dir_held),
    .overrun  (overrun)
  );

  // Clock
  initial begin
    CLK_50 = 1'b0;
    forever #5 CLK_50 = ~CLK_50;
  end

  // Edge counter and transfer log; edge n is labelled n.
  always @(posedge CLK_50) begin
    cyc = cyc + 1;
    if (resetn === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      xfer_cyc.push_back(cyc);
      xfer_dir.push_back(cmd_dir);
    end
  end

  task automatic tick();
    @(posedge CLK_50);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    SW = 4'b0000;
    cmd_ready = 1'b1;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    xfer_cyc.delete();
    xfer_dir.delete();
  endtask

  task automatic test_reset();
    bit bad;
    resetn = 1'b0;
    SW = 4'b0000;
    cmd_ready = 1'b1;
    repeat (2) tick();
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
    checks++; if (cmd_dir !== 2'd0) begin failures++; $display("FAIL reset_dir got=%0d exp=0", cmd_dir); end
    checks++; if (dir_held !== 4'b0000) begin failures++; $display("FAIL reset_held got=%b exp=0000", dir_held); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    resetn = 1'b1;
    tick();
    // Build up a pending command and an overrun while repeating right.
    SW = 4'b0010;
    cmd_ready = 1'b0;
    repeat (20) tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 2'd1) begin failures++; $display("FAIL mid_pre_cmd got=%b/%0d exp=1/1", cmd_valid, cmd_dir); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL mid_pre_overrun got=%b exp=1", overrun); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL async_valid got=%b exp=0", cmd_valid); end
    checks++; if (cmd_dir !== 2'd0) begin failures++; $display("FAIL async_dir got=%0d exp=0", cmd_dir); end
    checks++; if (dir_held !== 4'b0000) begin failures++; $display("FAIL async_held got=%b exp=0000", dir_held); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL async_overrun got=%b exp=0", overrun); end
    SW = 4'b0000;
    cmd_ready = 1'b1;
    tick();
    resetn = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (cmd_valid !== 1'b0 || dir_held !== 4'b0000) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL post_reset_idle got=%b/%b exp=0/0000", cmd_valid, dir_held); end
  endtask

  task automatic test_bounce();
    bit bad;
    int k;
    do_reset();
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      SW = 4'b0001;
      repeat (2) begin tick(); if (dir_held !== 4'b0000 || cmd_valid !== 1'b0) bad = 1'b1; end
      SW = 4'b0000;
      repeat (2) begin tick(); if (dir_held !== 4'b0000 || cmd_valid !== 1'b0) bad = 1'b1; end
    end
    repeat (10) begin tick(); if (dir_held !== 4'b0000 || cmd_valid !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin failures++; $display("FAIL bounce_filtered got=%b/%b exp=0000/0", dir_held, cmd_valid); end
    checks++; if (xfer_cyc.size() != 0) begin failures++; $display("FAIL bounce_no_step got=%0d exp=0", xfer_cyc.size()); end
    // Clean press: accepted 2 + DEB cycles after the edge.
    SW = 4'b0001;
    k = cyc;
    repeat (5) tick();
    checks++; if (dir_held !== 4'b0000) begin failures++; $display("FAIL press_early got=%b exp=0000", dir_held); end
    tick();
    checks++; if (dir_held !== 4'b0001 || cmd_valid !== 1'b0) begin failures++; $display("FAIL press_held got=%b/%b exp=0001/0", dir_held, cmd_valid); end
    tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 2'd0) begin failures++; $display("FAIL press_step got=%b/%0d exp=1/0", cmd_valid, cmd_dir); end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL press_one_cycle got=%b exp=0", cmd_valid); end
    SW = 4'b0000;
    repeat (20) tick();
    checks++; if (xfer_cyc.size() != 1 || dir_held !== 4'b0000) begin failures++; $display("FAIL press_total got=%0d/%b exp=1/0000", xfer_cyc.size(), dir_held); end
    else begin
      checks++; if (xfer_cyc[0] != k + 8) begin failures++; $display("FAIL press_xfer_cyc got=%0d exp=%0d", xfer_cyc[0] - k, 8); end
    end
  endtask

  task automatic test_auto_repeat();
    int k;
    int exp_off[9] = '{8, 18, 23, 28, 33, 38, 43, 48, 53};
    do_reset();
    SW = 4'b0010;
    k = cyc;
    repeat (46) tick();
    SW = 4'b0000;
    repeat (34) tick();
    checks++; if (xfer_cyc.size() != 9) begin failures++; $display("FAIL repeat_count got=%0d exp=9", xfer_cyc.size()); end
    for (int i = 0; i < 9 && i < xfer_cyc.size(); i++) begin
      checks++;
      if (xfer_cyc[i] != k + exp_off[i] || xfer_dir[i] !== 2'd1) begin
        failures++;
        $display("FAIL repeat_step%0d got=+%0d/dir%0d exp=+%0d/dir1", i, xfer_cyc[i] - k, xfer_dir[i], exp_off[i]);
      end
    end
    checks++; if (cmd_valid !== 1'b0 || dir_held !== 4'b0000) begin failures++; $display("FAIL repeat_release got=%b/%b exp=0/0000", cmd_valid, dir_held); end
  endtask

  task automatic test_priority_switch();
    int k;
    int exp_off[4] = '{8, 17, 27, 32};
    logic [1:0] exp_d[4];
    exp_d[0] = 2'd3; exp_d[1] = 2'd2; exp_d[2] = 2'd2; exp_d[3] = 2'd2;
    do_reset();
    SW = 4'b1000;
    k = cyc;
    repeat (9) tick();
    SW = 4'b1100;
    repeat (19) tick();
    SW = 4'b0000;
    repeat (20) tick();
    checks++; if (xfer_cyc.size() != 4) begin failures++; $display("FAIL prio_count got=%0d exp=4", xfer_cyc.size()); end
    for (int i = 0; i < 4 && i < xfer_cyc.size(); i++) begin
      checks++;
      if (xfer_cyc[i] != k + exp_off[i] || xfer_dir[i] !== exp_d[i]) begin
        failures++;
        $display("FAIL prio_step%0d got=+%0d/dir%0d exp=+%0d/dir%0d", i, xfer_cyc[i] - k, xfer_dir[i], exp_off[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit bad;
    int k;
    do_reset();
    cmd_ready = 1'b0;
    SW = 4'b0001;
    k = cyc;
    repeat (7) tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 2'd0 || overrun !== 1'b0) begin failures++; $display("FAIL bp_first got=%b/%0d/%b exp=1/0/0", cmd_valid, cmd_dir, overrun); end
    repeat (9) tick();
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL bp_before_repeat got=%b exp=0", overrun); end
    tick();
    checks++; if (overrun !== 1'b1 || cmd_valid !== 1'b1 || cmd_dir !== 2'd0) begin failures++; $display("FAIL bp_overrun got=%b/%b/%0d exp=1/1/0", overrun, cmd_valid, cmd_dir); end
    SW = 4'b0000;
    bad = 1'b0;
    repeat (7) begin tick(); if (cmd_valid !== 1'b1 || cmd_dir !== 2'd0) bad = 1'b1; end
    checks++; if (bad) begin failures++; $display("FAIL bp_hold got=%b/%0d exp=1/0", cmd_valid, cmd_dir); end
    cmd_ready = 1'b1;
    tick();
    checks++; if (cmd_valid !== 1'b0 || overrun !== 1'b1) begin failures++; $display("FAIL bp_drain got=%b/%b exp=0/1", cmd_valid, overrun); end
    bad = 1'b0;
    repeat (10) begin tick(); if (cmd_valid !== 1'b0) bad = 1'b1; end
    checks++; if (bad) begin failures++; $display("FAIL bp_quiet got=%b exp=0", cmd_valid); end
    checks++; if (xfer_cyc.size() != 1) begin failures++; $display("FAIL bp_xfer_count got=%0d exp=1", xfer_cyc.size()); end
    else begin
      checks++; if (xfer_cyc[0] != k + 25 || xfer_dir[0] !== 2'd0) begin failures++; $display("FAIL bp_xfer got=+%0d/dir%0d exp=+25/dir0", xfer_cyc[0] - k, xfer_dir[0]); end
    end
  endtask

  task automatic test_coincident();
    int k;
    do_reset();
    cmd_ready = 1'b0;
    SW = 4'b1000;
    k = cyc;
    repeat (3) tick();
    SW = 4'b1001;
    repeat (6) tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 2'd3) begin failures++; $display("FAIL coin_pending got=%b/%0d exp=1/3", cmd_valid, cmd_dir); end
    cmd_ready = 1'b1;
    tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_dir !== 2'd0 || overrun !== 1'b0) begin failures++; $display("FAIL coin_replace got=%b/%0d/%b exp=1/0/0", cmd_valid, cmd_dir, overrun); end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL coin_drain got=%b exp=0", cmd_valid); end
    SW = 4'b0000;
    repeat (15) tick();
    checks++; if (xfer_cyc.size() != 2) begin failures++; $display("FAIL coin_count got=%0d exp=2", xfer_cyc.size()); end
    else begin
      checks++; if (xfer_cyc[0] != k + 10 || xfer_dir[0] !== 2'd3) begin failures++; $display("FAIL coin_xfer0 got=+%0d/dir%0d exp=+10/dir3", xfer_cyc[0] - k, xfer_dir[0]); end
      checks++; if (xfer_cyc[1] != k + 11 || xfer_dir[1] !== 2'd0) begin failures++; $display("FAIL coin_xfer1 got=+%0d/dir%0d exp=+11/dir0", xfer_cyc[1] - k, xfer_dir[1]); end
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL coin_overrun got=%b exp=0", overrun); end
  endtask

  initial begin
    resetn = 1'b0;
    SW = 4'b0000;
    cmd_ready = 1'b1;
    test_reset();
    test_bounce();
    test_auto_repeat();
    test_priority_switch();
    test_backpressure();
    test_coincident();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
